// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: mode encodings,
// colour-bar palette and bouncing-box geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'b00,
    MODE_CHECKER  = 2'b01,
    MODE_GRADIENT = 2'b10,
    MODE_BOX      = 2'b11
  } mode_e;

  localparam logic [11:0] BAR_WHITE   = 12'hFFF;
  localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
  localparam logic [11:0] BAR_CYAN    = 12'h0FF;
  localparam logic [11:0] BAR_GREEN   = 12'h0F0;
  localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [11:0] BAR_RED     = 12'hF00;
  localparam logic [11:0] BAR_BLUE    = 12'h00F;
  localparam logic [11:0] BAR_BLACK   = 12'h000;

  localparam int BOX_SIZE = 32;

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position tracker: moves each axis by step per frame tick,
// reversing at the edges and clamping when the visible area shrinks.
module vga_box_mover
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [3:0]  step,
  input  logic [10:0] h_visible,
  input  logic [10:0] v_visible,
  output logic [10:0] box_x,
  output logic [10:0] box_y
);

  logic [1:0][10:0] pos_all;

  // Axis 0 is horizontal, axis 1 vertical; both share identical bounce rules.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic [10:0] vis;
    logic [10:0] lim;
    logic [10:0] pos_reg;
    logic [10:0] pos_next;
    logic        dir_dec_reg;
    logic        dir_dec_next;

    assign vis = (gi == 0) ? h_visible : v_visible;
    // Upper limit leaves room for the whole box; never below the minimum of 1.
    assign lim = (vis >= 11'(BOX_SIZE + 2)) ? vis - 11'(BOX_SIZE + 1) : 11'd1;

    always_comb begin
      pos_next     = pos_reg;
      dir_dec_next = dir_dec_reg;
      if (pos_reg > lim) begin
        pos_next = lim;
      end else if (!dir_dec_reg) begin
        if ({1'b0, pos_reg} + {8'd0, step} > {1'b0, lim}) begin
          pos_next     = lim;
          dir_dec_next = 1'b1;
        end else begin
          pos_next = pos_reg + {7'd0, step};
        end
      end else begin
        if ({1'b0, pos_reg} < 12'd1 + {8'd0, step}) begin
          pos_next     = 11'd1;
          dir_dec_next = 1'b0;
        end else begin
          pos_next = pos_reg - {7'd0, step};
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pos_reg     <= 11'd1;
        dir_dec_reg <= 1'b0;
      end else if (tick) begin
        pos_reg     <= pos_next;
        dir_dec_reg <= dir_dec_next;
      end
    end

    assign pos_all[gi] = pos_reg;
  end

  assign box_x = pos_all[0];
  assign box_y = pos_all[1];

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: detects frame start, latches mode/step per
// frame and produces a registered pixel colour one cycle after the counters.
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] h_cnt,
  input  logic [10:0] v_cnt,
  input  logic [10:0] h_back_porch,
  input  logic [10:0] h_visible,
  input  logic [10:0] v_back_porch,
  input  logic [10:0] v_visible,
  input  logic [1:0]  mode_sel,
  input  logic [3:0]  step,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        frame_tick
);

  logic [10:0] x;
  logic [10:0] y;
  logic [11:0] h_end;
  logic [11:0] v_end;
  logic        active;
  logic        in_box;
  logic [10:0] box_x;
  logic [10:0] box_y;
  logic [11:0] colour;

  mode_e       active_mode_reg;
  logic [3:0]  active_step_reg;
  logic [7:0]  frame_cnt;
  logic        frame_tick_reg;
  logic [11:0] pix_reg;

  assign x     = h_cnt - h_back_porch;
  assign y     = v_cnt - v_back_porch;
  assign h_end = {1'b0, h_back_porch} + {1'b0, h_visible};
  assign v_end = {1'b0, v_back_porch} + {1'b0, v_visible};

  assign active = (h_cnt > h_back_porch) && ({1'b0, h_cnt} < h_end) &&
                  (v_cnt > v_back_porch) && ({1'b0, v_cnt} < v_end);

  assign in_box = (x >= box_x) && ({1'b0, x} < {1'b0, box_x} + 12'(BOX_SIZE)) &&
                  (y >= box_y) && ({1'b0, y} < {1'b0, box_y} + 12'(BOX_SIZE));

  always_comb begin
    colour = BAR_BLACK;
    if (active) begin
      case (active_mode_reg)
        MODE_BARS:     colour = bar_colour(x[9:7]);
        MODE_CHECKER:  colour = (x[5] ^ y[5]) ? BAR_WHITE : BAR_BLACK;
        MODE_GRADIENT: colour = {x[9:6], y[9:6], frame_cnt[3:0]};
        MODE_BOX:      colour = in_box ? BAR_RED : BAR_BLUE;
        default:       colour = BAR_BLACK;
      endcase
    end
  end

  // Mode/step are sampled only on the tick so a frame never mixes patterns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_reg         <= 12'h000;
      frame_tick_reg  <= 1'b0;
      frame_cnt       <= 8'd0;
      active_mode_reg <= MODE_BARS;
      active_step_reg <= 4'd0;
    end else begin
      pix_reg        <= colour;
      frame_tick_reg <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
      if (frame_tick_reg) begin
        frame_cnt       <= frame_cnt + 8'd1;
        active_mode_reg <= mode_e'(mode_sel);
        active_step_reg <= step;
      end
    end
  end

  // The mover sees the step latched on the previous tick.
  vga_box_mover u_box (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (frame_tick_reg),
    .step      (active_step_reg),
    .h_visible (h_visible),
    .v_visible (v_visible),
    .box_x     (box_x),
    .box_y     (box_y)
  );

  assign pix_r      = pix_reg[11:8];
  assign pix_g      = pix_reg[7:4];
  assign pix_b      = pix_reg[3:0];
  assign frame_tick = frame_tick_reg;

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: pixel clock, same clock as the timing stage.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port h_cnt, input, 11 bits: horizontal counter from the timing stage.
REQ-004 SHALL have port v_cnt, input, 11 bits: vertical counter from the timing stage.
REQ-005 SHALL have ports h_back_porch, h_visible, v_back_porch, v_visible, input, 11 bits each: active-mode timing parameters.
REQ-006 SHALL have port mode_sel, input, 2 bits: 00 colour bars, 01 checkerboard, 10 gradient, 11 bouncing box.
REQ-007 SHALL have port step, input, 4 bits: box motion in pixels per frame.
REQ-008 SHALL have ports pix_r, pix_g, pix_b, output, 4 bits each: pixel colour fed to the timing stage's in_r/in_g/in_b.
REQ-009 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at frame start.

Function
REQ-010 SHALL define x = h_cnt - h_back_porch and y = v_cnt - v_back_porch, each 11-bit unsigned.
REQ-011 SHALL treat a pixel as active iff h_cnt > h_back_porch, h_cnt < h_back_porch + h_visible, v_cnt > v_back_porch and v_cnt < v_back_porch + v_visible.
REQ-012 SHALL register pix_r/g/b with 1-cycle latency from h_cnt/v_cnt, and SHALL output 0 for inactive pixels.
REQ-013 SHALL assert frame_tick for exactly one cycle, the cycle after h_cnt==0 and v_cnt==0 are sampled.
REQ-014 SHALL latch mode_sel and step into active_mode and active_step only on frame_tick, so that mid-frame changes take effect at the next frame.
REQ-015 SHALL, in mode 00, use bar index x[9:7] mapped 0..7 to FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-016 SHALL, in mode 01, output FFF when x[5] XOR y[5] is 1, else 000.
REQ-017 SHALL, in mode 10, output r=x[9:6], g=y[9:6], b=frame_cnt[3:0], where frame_cnt is an 8-bit counter incremented on frame_tick that wraps 255 to 0.
REQ-018 SHALL, in mode 11, output F00 when box_x <= x < box_x+32 and box_y <= y < box_y+32, else 00F.
REQ-019 SHALL update box_x/box_y on each frame_tick by +/- active_step according to direction flags dx/dy.
REQ-020 SHALL limit the box to x_max = h_visible-33 and y_max = v_visible-33, with minimum 1.
REQ-021 SHALL, when box_x+step > x_max while moving +, set box_x = x_max and reverse dx; when box_x < 1+step while moving -, set box_x = 1 and reverse dx; y SHALL behave identically.
REQ-022 SHALL clamp the box position into range on the next frame_tick if timing parameters shrink and leave it out of range, without reversing direction.
REQ-023 SHALL hold the box still when active_step == 0; boundary clamps SHALL still apply.
REQ-024 SHALL update box position and frame_cnt only on frame_tick, regardless of the active mode.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear pix_r/g/b to 0, frame_tick to 0, frame_cnt to 0, active_mode to 00 and active_step to 0.
REQ-026 SHALL, on rst_n low, set box_x = box_y = 1 and dx = dy = + (increasing).
REQ-027 SHALL resume on the first clk edge after rst_n rises, with no pending tick or mode change.

Structure
REQ-028 SHALL place mode encodings, the eight bar colour constants and BOX_SIZE = 32 in shared package vga_pkg.
REQ-029 SHALL implement box position, direction and clamping (REQ-019 to REQ-023) in sub-module vga_box_mover.
REQ-030 SHALL keep frame detection, latching and pixel muxing in the top level.

Verification (640x480: HBP=48, HVIS=640, VBP=33, VVIS=480)
REQ-031 Reset asserted mid-line -> pix=000 and frame_tick=0 immediately; box=(1,1) after release.
REQ-032 mode 00 latched, v_cnt=100, h_cnt=49 -> pix=FFF next cycle; h_cnt=178 -> FF0; h_cnt=20 -> 000.
REQ-033 mode_sel changes 00 to 01 at v_cnt=200 -> bars continue until frame_tick, then checkerboard; x=32,y=1 -> FFF.
REQ-034 mode 11, step=8, box_x=600, dx=+ -> next tick box_x=607, dx=-; following tick box_x=599.
REQ-035 box_y=3, dy=-, step=8 -> next tick box_y=1, dy=+.
REQ-036 mode 10 over 256 frames -> pix_b wraps 15 to 0 sixteen times, frame_cnt wraps to 0.
